// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - stage tag and hazard control bundle between pipeline and hazard_ctrl
interface hazard_ctrl_if;
    // D-stage sources and first-use stage (0=D, 1=E, 3=unused)
    logic [4:0] ra1D;
    logic [4:0] ra2D;
    logic [1:0] tuse1D;
    logic [1:0] tuse2D;
    // E-stage sources
    logic [4:0] ra1E;
    logic [4:0] ra2E;
    // Destination register and result type per stage
    logic [4:0] waE;
    logic [4:0] waM;
    logic [4:0] waW;
    logic [1:0] resE;
    logic [1:0] resM;
    logic [1:0] resW;
    // Mult/div sequencing
    logic       mdUseD;
    logic       mdStartE;
    logic       mdTypeE;
    // Controls back to the pipeline
    logic       stall;
    logic       flushE;
    logic [1:0] fwd1D;
    logic [1:0] fwd2D;
    logic [1:0] fwd1E;
    logic [1:0] fwd2E;
    logic       mdBusy;

    // Pipeline side: drives stage tags, consumes controls
    modport master (
        output ra1D, ra2D, tuse1D, tuse2D, ra1E, ra2E,
        output waE, waM, waW, resE, resM, resW,
        output mdUseD, mdStartE, mdTypeE,
        input  stall, flushE, fwd1D, fwd2D, fwd1E, fwd2E, mdBusy
    );

    // Controller side
    modport slave (
        input  ra1D, ra2D, tuse1D, tuse2D, ra1E, ra2E,
        input  waE, waM, waW, resE, resM, resW,
        input  mdUseD, mdStartE, mdTypeE,
        output stall, flushE, fwd1D, fwd2D, fwd1E, fwd2E, mdBusy
    );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall, bubble and forwarding control with mult/div busy sequencing
module hazard_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input logic         clk,
    input logic         rst,
    hazard_ctrl_if.slave hz
);

    // Result type encodings carried in the stage registers
    localparam logic [1:0] RES_NONE = 2'b00;
    localparam logic [1:0] RES_ALU  = 2'b01;
    localparam logic [1:0] RES_LOAD = 2'b10;
    localparam logic [1:0] RES_LINK = 2'b11;

    // First-use encoding meaning "this operand is not read"
    localparam logic [1:0] TUSE_NONE = 2'b11;

    // D-stage forward selects
    localparam logic [1:0] FD_RF = 2'b00;
    localparam logic [1:0] FD_E  = 2'b01;
    localparam logic [1:0] FD_M  = 2'b10;
    localparam logic [1:0] FD_W  = 2'b11;

    // E-stage forward selects
    localparam logic [1:0] FE_PIPE = 2'b00;
    localparam logic [1:0] FE_M    = 2'b01;
    localparam logic [1:0] FE_W    = 2'b10;

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

    // Producer in a stage matches a consumer; $0 is hardwired zero so it
    // never creates a dependency, and type 00 writes nothing.
    function automatic logic match(input logic [4:0] src,
                                   input logic [4:0] wa,
                                   input logic [1:0] res);
        return (src != 5'd0) && (src == wa) && (res != RES_NONE);
    endfunction

    // Cycles until an E-stage producer has its value available.
    function automatic logic [1:0] tnew_e(input logic [1:0] res);
        case (res)
            RES_ALU:  return 2'd1;
            RES_LOAD: return 2'd2;
            RES_LINK: return 2'd0;
            default:  return 2'd0;
        endcase
    endfunction

    // Cycles until an M-stage producer has its value available.
    function automatic logic [1:0] tnew_m(input logic [1:0] res);
        case (res)
            RES_ALU:  return 2'd0;
            RES_LOAD: return 2'd1;
            RES_LINK: return 2'd0;
            default:  return 2'd0;
        endcase
    endfunction

    // One D operand stalls when its producer in E or M is too late for it.
    function automatic logic src_stall(input logic [4:0] src,
                                       input logic [1:0] tuse,
                                       input logic [4:0] wa_e,
                                       input logic [1:0] res_e,
                                       input logic [4:0] wa_m,
                                       input logic [1:0] res_m);
        logic hit_e;
        logic hit_m;
        hit_e = match(src, wa_e, res_e) && (tnew_e(res_e) > tuse);
        hit_m = match(src, wa_m, res_m) && (tnew_m(res_m) > tuse);
        return (tuse != TUSE_NONE) && (hit_e || hit_m);
    endfunction

    // D operand select: the youngest ready producer wins.
    function automatic logic [1:0] sel_d(input logic [4:0] src,
                                         input logic [4:0] wa_e,
                                         input logic [1:0] res_e,
                                         input logic [4:0] wa_m,
                                         input logic [1:0] res_m,
                                         input logic [4:0] wa_w,
                                         input logic [1:0] res_w);
        if (match(src, wa_e, res_e) && (tnew_e(res_e) == 2'd0)) begin
            return FD_E;
        end else if (match(src, wa_m, res_m) && (tnew_m(res_m) == 2'd0)) begin
            return FD_M;
        end else if (match(src, wa_w, res_w)) begin
            return FD_W;
        end
        return FD_RF;
    endfunction

    // E operand select: M beats W, otherwise keep the pipe register value.
    function automatic logic [1:0] sel_e(input logic [4:0] src,
                                         input logic [4:0] wa_m,
                                         input logic [1:0] res_m,
                                         input logic [4:0] wa_w,
                                         input logic [1:0] res_w);
        if (match(src, wa_m, res_m) && (tnew_m(res_m) == 2'd0)) begin
            return FE_M;
        end else if (match(src, wa_w, res_w)) begin
            return FE_W;
        end
        return FE_PIPE;
    endfunction

    logic [CNT_W-1:0] md_cnt_q;
    logic [CNT_W-1:0] md_cnt_d;
    logic             md_busy;
    logic             data_stall;
    logic             md_stall;

    assign md_busy = (md_cnt_q != '0);

    // Busy counter next state: a new start reloads (even over a running op),
    // otherwise count down to idle. Stalls do not freeze the unit.
    always_comb begin
        md_cnt_d = md_cnt_q;
        if (hz.mdStartE) begin
            md_cnt_d = hz.mdTypeE ? DIV_LOAD : MULT_LOAD;
        end else if (md_busy) begin
            md_cnt_d = md_cnt_q - 1'b1;
        end
    end

    // Busy counter register; reset abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            md_cnt_q <= '0;
        end else begin
            md_cnt_q <= md_cnt_d;
        end
    end

    // Stall/bubble and forward selects, purely from the current stage tags.
    always_comb begin
        data_stall = src_stall(hz.ra1D, hz.tuse1D, hz.waE, hz.resE, hz.waM, hz.resM)
                   | src_stall(hz.ra2D, hz.tuse2D, hz.waE, hz.resE, hz.waM, hz.resM);
        // A start in E this cycle counts as busy for a HI/LO user in D.
        md_stall   = hz.mdUseD && (md_busy || hz.mdStartE);
        hz.stall   = data_stall | md_stall;
        hz.flushE  = data_stall | md_stall;
        hz.fwd1D   = sel_d(hz.ra1D, hz.waE, hz.resE, hz.waM, hz.resM, hz.waW, hz.resW);
        hz.fwd2D   = sel_d(hz.ra2D, hz.waE, hz.resE, hz.waM, hz.resM, hz.waW, hz.resW);
        hz.fwd1E   = sel_e(hz.ra1E, hz.waM, hz.resM, hz.waW, hz.resW);
        hz.fwd2E   = sel_e(hz.ra2E, hz.waM, hz.resM, hz.waW, hz.resW);
        hz.mdBusy  = md_busy;
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    hazard_ctrl_if hz ();

    hazard_ctrl #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10),
        .CNT_W      (4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .hz (hz.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        hz.ra1D = 0; hz.ra2D = 0; hz.tuse1D = 2'd3; hz.tuse2D = 2'd3;
        hz.ra1E = 0; hz.ra2E = 0;
        hz.waE = 0; hz.waM = 0; hz.waW = 0;
        hz.resE = 0; hz.resM = 0; hz.resW = 0;
        hz.mdUseD = 0; hz.mdStartE = 0; hz.mdTypeE = 0;
    endtask

    // Advance to the next cycle's sampling window (inputs change at negedge).
    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1;
        idle();
        step(); step();
        #1;
        chk("rst_busy",  {3'b0, hz.mdBusy}, 4'h0);
        chk("rst_stall", {3'b0, hz.stall},  4'h0);
        chk("rst_flush", {3'b0, hz.flushE}, 4'h0);
        chk("rst_fwd1D", {2'b0, hz.fwd1D},  4'h0);
        chk("rst_fwd2D", {2'b0, hz.fwd2D},  4'h0);
        chk("rst_fwd1E", {2'b0, hz.fwd1E},  4'h0);
        chk("rst_fwd2E", {2'b0, hz.fwd2E},  4'h0);
        step();
        rst = 1'b0;

        // Load-use: load in E, consumer needs it in E
        step(); idle();
        hz.resE = 2'b10; hz.waE = 8; hz.ra1D = 8; hz.tuse1D = 2'd1;
        #1;
        chk("lu_stall", {3'b0, hz.stall},  4'h1);
        chk("lu_flush", {3'b0, hz.flushE}, 4'h1);
        // load now in M (tnewM=1 not > tuse 1), bubble in E
        step(); idle();
        hz.resM = 2'b10; hz.waM = 8; hz.ra1D = 8; hz.tuse1D = 2'd1;
        #1;
        chk("lu_m_stall", {3'b0, hz.stall}, 4'h0);
        chk("lu_m_fwd1D", {2'b0, hz.fwd1D}, 4'h0);
        // consumer in E, load in W
        step(); idle();
        hz.resW = 2'b10; hz.waW = 8; hz.ra1E = 8;
        #1;
        chk("lu_w_fwd1E", {2'b0, hz.fwd1E}, 4'h2);

        // ALU result feeding a branch in D
        step(); idle();
        hz.resE = 2'b01; hz.waE = 9; hz.ra1D = 9; hz.tuse1D = 2'd0;
        #1;
        chk("br_stall", {3'b0, hz.stall}, 4'h1);
        chk("br_fwd1D", {2'b0, hz.fwd1D}, 4'h0);
        step(); idle();
        hz.resM = 2'b01; hz.waM = 9; hz.ra1D = 9; hz.tuse1D = 2'd0;
        #1;
        chk("br_m_stall", {3'b0, hz.stall}, 4'h0);
        chk("br_m_fwd1D", {2'b0, hz.fwd1D}, 4'h2);

        // Link value is ready in E
        step(); idle();
        hz.resE = 2'b11; hz.waE = 31; hz.ra2D = 31; hz.tuse2D = 2'd0;
        #1;
        chk("lnk_stall", {3'b0, hz.stall}, 4'h0);
        chk("lnk_fwd2D", {2'b0, hz.fwd2D}, 4'h1);

        // $0 never stalls or forwards
        step(); idle();
        hz.resE = 2'b10; hz.waE = 0; hz.ra1D = 0; hz.tuse1D = 2'd0;
        hz.resW = 2'b01; hz.waW = 0; hz.ra1E = 0;
        #1;
        chk("z_stall", {3'b0, hz.stall}, 4'h0);
        chk("z_fwd1D", {2'b0, hz.fwd1D}, 4'h0);
        chk("z_fwd1E", {2'b0, hz.fwd1E}, 4'h0);

        // Unused operand ignores a matching load
        step(); idle();
        hz.resE = 2'b10; hz.waE = 5; hz.ra1D = 5; hz.tuse1D = 2'd3;
        #1;
        chk("tu3_stall", {3'b0, hz.stall}, 4'h0);

        // Load in M vs branch operand on port 2
        step(); idle();
        hz.resM = 2'b10; hz.waM = 6; hz.ra2D = 6; hz.tuse2D = 2'd0;
        #1;
        chk("ldm_stall", {3'b0, hz.stall}, 4'h1);

        // Type 00 in E does not hazard
        step(); idle();
        hz.resE = 2'b00; hz.waE = 6; hz.ra1D = 6; hz.tuse1D = 2'd0;
        #1;
        chk("none_stall", {3'b0, hz.stall}, 4'h0);
        chk("none_fwd1D", {2'b0, hz.fwd1D}, 4'h0);

        // Forward priority: E link > M ALU > W
        step(); idle();
        hz.resE = 2'b11; hz.waE = 4; hz.resM = 2'b01; hz.waM = 4;
        hz.resW = 2'b10; hz.waW = 4; hz.ra1D = 4; hz.tuse1D = 2'd1;
        hz.ra2E = 4;
        #1;
        chk("pri_EMW", {2'b0, hz.fwd1D}, 4'h1);
        chk("pri_E_MW", {2'b0, hz.fwd2E}, 4'h1);
        hz.resE = 2'b00;
        #1;
        chk("pri_MW", {2'b0, hz.fwd1D}, 4'h2);
        hz.resM = 2'b00;
        #1;
        chk("pri_W", {2'b0, hz.fwd1D}, 4'h3);
        chk("pri_E_W", {2'b0, hz.fwd2E}, 4'h2);

        // Div followed by mflo held in D
        step(); idle();
        hz.mdStartE = 1; hz.mdTypeE = 1; hz.mdUseD = 1;
        #1;
        chk("div_c0_stall", {3'b0, hz.stall},  4'h1);
        chk("div_c0_busy",  {3'b0, hz.mdBusy}, 4'h0);
        for (int i = 1; i <= 10; i++) begin
            step();
            hz.mdStartE = 0;
            #1;
            chk($sformatf("div_c%0d_stall", i), {3'b0, hz.stall},  4'h1);
            chk($sformatf("div_c%0d_busy", i),  {3'b0, hz.mdBusy}, 4'h1);
        end
        step();
        #1;
        chk("div_c11_stall", {3'b0, hz.stall},  4'h0);
        chk("div_c11_busy",  {3'b0, hz.mdBusy}, 4'h0);

        // Mult: busy cycles 1..5, no stall without a HI/LO user
        step(); idle();
        hz.mdStartE = 1; hz.mdTypeE = 0;
        for (int i = 1; i <= 5; i++) begin
            step();
            hz.mdStartE = 0;
            #1;
            if (i == 5) begin
                chk("mul_c5_busy",  {3'b0, hz.mdBusy}, 4'h1);
                chk("mul_c5_stall", {3'b0, hz.stall},  4'h0);
            end
        end
        step();
        #1;
        chk("mul_c6_busy", {3'b0, hz.mdBusy}, 4'h0);

        // Restart while busy: div reloads over a running mult
        step(); idle();
        hz.mdStartE = 1; hz.mdTypeE = 0;
        step(); hz.mdStartE = 0;
        step(); hz.mdStartE = 1; hz.mdTypeE = 1;
        for (int i = 1; i <= 10; i++) begin
            step();
            hz.mdStartE = 0;
            #1;
            if (i == 6) chk("rs_c6_busy", {3'b0, hz.mdBusy}, 4'h1);
            if (i == 10) chk("rs_c10_busy", {3'b0, hz.mdBusy}, 4'h1);
        end
        step();
        #1;
        chk("rs_c11_busy", {3'b0, hz.mdBusy}, 4'h0);

        // Reset mid-div
        step(); idle();
        hz.mdStartE = 1; hz.mdTypeE = 1; hz.mdUseD = 1;
        step(); hz.mdStartE = 0;
        step();
        step();
        #1;
        chk("rd_c3_busy", {3'b0, hz.mdBusy}, 4'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("rd_c4_busy",  {3'b0, hz.mdBusy}, 4'h0);
        chk("rd_c4_stall", {3'b0, hz.stall},  4'h0);

        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety net in case the sequence above stalls
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
